// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches one word per request into a
// buffer, and transfers it to the IR on the control FSM's load strobe.
//   state  | meaning
//   S_REQ  | read request outstanding at pc, counting wait cycles
//   S_HOLD | fetched word in buffer, waiting for load_ir / write_pc
//   S_ERR  | memory timed out; frozen until RST
module if_stage #(
  parameter int unsigned           ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC    = '0,
  parameter int unsigned           MEM_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              write_pc,
  input  logic              load_ir,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [31:0]       instr,
  output logic [6:0]        op_code,
  output logic [4:0]        rd,
  output logic [2:0]        funct3,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [6:0]        funct7,
  output logic              ir_valid,
  output logic              fetch_busy,
  output logic              fetch_err
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_ERR} state_t;

  localparam logic [7:0]  TMO     = 8'(MEM_TIMEOUT);
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [31:0]         buf_q, buf_d;
  logic                ir_valid_q, ir_valid_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;

  logic [ADDR_W-1:0]   pc_seq;
  logic [ADDR_W-1:0]   pc_tgt;
  logic [7:0]          cnt_inc;
  logic                misaligned;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INS;
      buf_q      <= '0;
      ir_valid_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      buf_q      <= buf_d;
      ir_valid_q <= ir_valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_seq     = pc_q + ADDR_W'(4);
  assign pc_tgt     = {branch_target[ADDR_W-1:2], 2'b00};
  assign misaligned = pc_src && (branch_target[1:0] != 2'b00);
  assign cnt_inc    = cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    buf_d      = buf_q;
    ir_valid_d = ir_valid_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_REQ: begin
        // A redirect abandons the outstanding read, even if it completes now.
        if (write_pc) begin
          pc_d    = pc_src ? pc_tgt : pc_seq;
          err_d   = err_q | misaligned;
          cnt_d   = '0;
        end else if (mem_ready) begin
          buf_d   = mem_rdata;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TMO) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (load_ir) begin
          ir_d       = buf_q;
          ir_valid_d = 1'b1;
        end
        if (write_pc) begin
          pc_d    = pc_src ? pc_tgt : pc_seq;
          err_d   = err_q | misaligned;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  assign mem_req    = (state_q == S_REQ);
  assign fetch_busy = (state_q != S_HOLD);
  assign fetch_err  = err_q;
  assign mem_addr   = pc_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_seq;
  assign instr      = ir_q;
  assign ir_valid   = ir_valid_q;

  assign op_code = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign funct7  = ir_q[31:25];

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a behavioural fetch model predicts each
// cycle's outputs; a monitor compares them on the falling edge.
module tb_if_stage;

  localparam int TMO = 15;

  logic        CLK, RST;
  logic        write_pc, load_ir, pc_src, mem_ready;
  logic [31:0] branch_target, mem_rdata;
  logic        mem_req, ir_valid, fetch_busy, fetch_err;
  logic [31:0] mem_addr, pc, pc_plus4, instr;
  logic [6:0]  op_code, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  if_stage #(.ADDR_W(32), .RESET_PC(32'h0), .MEM_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .write_pc(write_pc), .load_ir(load_ir),
    .pc_src(pc_src), .branch_target(branch_target), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .op_code(op_code),
    .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .ir_valid(ir_valid), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mem_req;
    logic        busy;
    logic        err;
    logic        irv;
  } snap_t;

  snap_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model: "waiting" means a read is outstanding, "dead" means timed out.
  logic [31:0] m_pc, m_ir, m_buf;
  bit          m_irv, m_err, m_wait, m_dead;
  int          m_cnt;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic void model_reset();
    m_pc = 32'h0; m_ir = 32'h0000_0013; m_buf = 32'h0;
    m_irv = 0; m_err = 0; m_wait = 1; m_dead = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(bit wp, bit li, bit src, logic [31:0] tgt,
                                     bit rdy, logic [31:0] rdata);
    if (m_dead) return;
    if (!m_wait && li) begin
      m_ir  = m_buf;
      m_irv = 1;
    end
    if (wp) begin
      if (src) begin
        if (tgt % 4 != 0) m_err = 1;
        m_pc = tgt - (tgt % 4);
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_wait = 1;
      m_cnt  = 0;
    end else if (m_wait) begin
      if (rdy) begin
        m_buf  = rdata;
        m_wait = 0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
        if (m_cnt >= TMO) begin
          m_dead = 1;
          m_err  = 1;
        end
      end
    end
  endfunction

  function automatic void push_expected();
    snap_t s;
    s.pc      = m_pc;
    s.instr   = m_ir;
    s.mem_req = m_wait && !m_dead;
    s.busy    = m_wait || m_dead;
    s.err     = m_err;
    s.irv     = m_irv;
    sb.push_back(s);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: outputs reflect state after the last rising edge.
  initial begin
    snap_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc",         pc,                e.pc);
        chk("mem_addr",   mem_addr,          e.pc);
        chk("pc_plus4",   pc_plus4,          e.pc + 32'd4);
        chk("mem_req",    {31'b0, mem_req},  {31'b0, e.mem_req});
        chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, e.busy});
        chk("fetch_err",  {31'b0, fetch_err},  {31'b0, e.err});
        chk("ir_valid",   {31'b0, ir_valid},   {31'b0, e.irv});
        chk("instr",      instr,             e.instr);
        chk("op_code",    {25'b0, op_code},  {25'b0, e.instr[6:0]});
        chk("rd",         {27'b0, rd},       {27'b0, e.instr[11:7]});
        chk("funct3",     {29'b0, funct3},   {29'b0, e.instr[14:12]});
        chk("rs1",        {27'b0, rs1},      {27'b0, e.instr[19:15]});
        chk("rs2",        {27'b0, rs2},      {27'b0, e.instr[24:20]});
        chk("funct7",     {25'b0, funct7},   {25'b0, e.instr[31:25]});
      end
    end
  end

  task automatic idle_inputs();
    write_pc = 0; load_ir = 0; pc_src = 0; branch_target = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  // Called at posedge+2; returns at the next posedge+2.
  task automatic step(input bit wp, input bit li, input bit src, input logic [31:0] tgt,
                      input bit rdy, input logic [31:0] rdata);
    write_pc = wp; load_ir = li; pc_src = src; branch_target = tgt;
    mem_ready = rdy; mem_rdata = rdata;
    push_expected();
    model_step(wp, li, src, tgt, rdy, rdata);
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1;
    model_reset();
    #1;
    push_expected();
    repeat (2) @(posedge CLK);
    #2;
    RST = 0;
  endtask

  initial begin
    bit          wp, li, src, rdy;
    logic [31:0] tgt, rdata;
    RST = 1;
    idle_inputs();
    model_reset();
    @(posedge CLK);
    #2;
    do_reset();

    // Reset sequencing and first load
    step(0, 0, 0, 0, 1, 32'h0050_0093);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Sequential fetch with wait states
    step(1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 32'hBAD0_BAD0);
    step(0, 0, 0, 0, 1, 32'h0010_0113);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0020_8193);
    // Branch with simultaneous load
    step(1, 1, 1, 32'h40, 0, 0);
    step(0, 0, 0, 0, 1, 32'h1234_5678);
    // Misaligned target, sticky error
    step(1, 0, 1, 32'h43, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0000_0033);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0000_0073);
    step(0, 1, 0, 0, 0, 0);
    // Wrap and mid-request redirect
    step(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 0, 0, 1, 32'hAAAA_5555);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 32'h100, 1, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h00C0_006F);
    step(0, 1, 0, 0, 0, 0);

    // Timeout: ERR after TMO waiting cycles, inputs ignored there
    do_reset();
    repeat (TMO) step(0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h80, 1, 32'h1111_1111);
    step(1, 0, 0, 0, 1, 32'h2222_2222);
    step(0, 0, 0, 0, 0, 0);
    do_reset();
    // Ready on the last allowed cycle wins over timeout
    repeat (TMO - 1) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0FF0_0F13);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ((m_dead && $urandom_range(0, 5) == 0) || (n % 600 == 599)) begin
        do_reset();
      end else begin
        wp  = ($urandom_range(0, 5) == 0);
        li  = ($urandom_range(0, 2) == 0);
        src = $urandom_range(0, 1) == 1;
        tgt = $urandom;
        if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
        if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFFC;
        rdata = $urandom;
        rdy = (n >= 2000) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
        step(wp, li, src, tgt, rdy, rdata);
      end
    end

    @(negedge CLK);
    @(negedge CLK);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the multicycle RISC-V core. Sits directly upstream of the control state machine.
- Owns the PC register and issues read requests to instruction memory with a ready handshake.
- Holds the fetched word in a fetch buffer and loads it into the instruction register (IR) on the control FSM's LOAD_IR strobe.
- Drives op_code and the decoded register/function fields consumed by the control FSM and the datapath.

Parameters:
- ADDR_W, 32, width of PC, mem_addr and branch_target.
- RESET_PC, 0, PC value loaded by reset.
- MEM_TIMEOUT, 15, maximum cycles in REQ without mem_ready before error (range 1..255).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- write_pc  in  1  PC update strobe (control FSM WRITE_PC).
- load_ir  in  1  IR load strobe (control FSM LOAD_IR).
- pc_src  in  1  0: next PC = pc+4; 1: next PC = branch_target.
- branch_target  in  ADDR_W  jump/branch target from ALU.
- mem_req  out  1  instruction read request.
- mem_addr  out  ADDR_W  read address; always equals pc.
- mem_rdata  in  32  read data, valid only in a cycle where mem_ready=1.
- mem_ready  in  1  memory completion; sampled only while mem_req=1.
- pc  out  ADDR_W  current PC.
- pc_plus4  out  ADDR_W  pc+4, wraps modulo 2^ADDR_W.
- instr  out  32  IR contents.
- op_code  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct7  out  7  instr[31:25].
- ir_valid  out  1  IR holds a word loaded since reset.
- fetch_busy  out  1  1 while the state is not HOLD.
- fetch_err  out  1  sticky error flag, cleared only by RST.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc=RESET_PC, IR=32'h0000_0013 (NOP), fetch buffer=0, ir_valid=0, fetch_err=0, timeout counter=0, state=REQ.
  - So mem_req=1 in the first cycle after RST deasserts.
- States:
  - REQ: mem_req=1, fetch_busy=1, counter increments each cycle. mem_ready=1 captures mem_rdata into the buffer, clears the counter and goes to HOLD.
  - HOLD: mem_req=0, fetch_busy=0, buffer valid; waits for load_ir and/or write_pc.
  - ERR: mem_req=0, fetch_busy=1, fetch_err=1. Ignores all inputs except RST. Exit only via RST.
- Timeout: the counter reaching MEM_TIMEOUT in REQ with mem_ready=0 sends the FSM to ERR on that edge. mem_ready in the same cycle wins (goes to HOLD).
- load_ir:
  - In HOLD: IR<=buffer and ir_valid<=1 at the edge; the new fields are visible next cycle.
  - Outside HOLD: ignored, IR unchanged.
  - Repeated load_ir in HOLD reloads the same word.
- write_pc:
  - In REQ or HOLD: pc<=(pc_src ? branch_target : pc+4), then state<=REQ and counter<=0.
  - In REQ, a coincident mem_ready is discarded and the new address is requested from the next cycle.
  - Ignored in ERR.
- write_pc and load_ir together in HOLD: IR loads the current buffer (the old PC's word), PC updates, state goes to REQ. Both effects take place at the same edge.
- Misaligned target (pc_src=1, branch_target[1:0]!=0): PC loads the target with bits[1:0] forced to 0 and fetch_err is set (sticky). Fetching continues normally.
- PC arithmetic wraps: pc=2^ADDR_W-4 with pc_src=0 gives pc=0, no error.
- mem_addr is combinationally equal to pc and is stable for the whole REQ interval unless write_pc fires.
- Latency:
  - RST release to buffer valid is 1 cycle + memory wait states.
  - Minimum write_pc to HOLD is 2 edges (1 edge to REQ, 1 edge with mem_ready=1).

Test Plan:
- Reset sequencing: release RST, mem_ready=1 on first REQ cycle with mem_rdata=32'h00500093 → HOLD next cycle. Then load_ir → instr=32'h00500093, op_code=7'b0010011, rd=1, rs1=0, ir_valid=1.
- Sequential fetch: in HOLD pulse write_pc with pc_src=0 → pc=4, mem_req=1, mem_addr=4. Hold mem_ready low 3 cycles then high → buffer captured, fetch_busy=0.
- Branch with simultaneous load: in HOLD at pc=8 apply write_pc=1, load_ir=1, pc_src=1, branch_target=32'h40 → IR gets pc=8 word, pc=32'h40, state REQ.
- Misaligned target: branch_target=32'h43 → pc=32'h40, fetch_err=1 and stays 1 after later normal fetches.
- Timeout: MEM_TIMEOUT=15, keep mem_ready=0 → ERR after 15 REQ cycles, mem_req=0, fetch_err=1. write_pc/load_ir ignored; RST returns pc=RESET_PC and fetch_err=0.
- Wrap and mid-request redirect: pc=32'hFFFF_FFFC, write_pc with pc_src=0 → pc=0. During REQ apply write_pc coincident with mem_ready=1 → data discarded, state remains REQ at the new pc.
